// File: rtl/glitch_filter_pkg.sv
// Shared types for the glitch filter: filtering mode encoding and counter sizing.
// Pure declarations, no logic, no latency, no backpressure.
package glitch_filter_pkg;

    typedef enum logic [1:0] {
        MODE_STRETCH  = 2'd0,
        MODE_FILTER   = 2'd1,
        MODE_DEBOUNCE = 2'd2
    } mode_e;

    // Counter only ever needs to reach DEPTH-1; keep at least one bit for DEPTH<=2.
    function automatic int cnt_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/glitch_filter_ch.sv
// One filter channel: synchroniser, window counter, mode logic and registered edge pulses.
// Latency SYNC_STAGES edges to first out change; no backpressure, en=0 freezes cnt/out and zeroes rise/fall.
module glitch_filter_ch
    import glitch_filter_pkg::*;
#(
    parameter int    DEPTH       = 3,
    parameter mode_e MODE        = MODE_STRETCH,
    parameter int    SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic data,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

    logic          s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          out_next;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = data;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Synchroniser keeps running while en=0 so resuming sees fresh samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= data;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        cnt_next = cnt;
        out_next = out;
        case (MODE)
            MODE_STRETCH: begin
                if (s) begin
                    out_next = 1'b1;
                    cnt_next = CNT_MAX;
                end else if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    out_next = 1'b0;
                end
            end
            MODE_FILTER: begin
                if (!s) begin
                    out_next = 1'b0;
                    cnt_next = '0;
                end else if (cnt == CNT_MAX) begin
                    out_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            MODE_DEBOUNCE: begin
                if (s == out) begin
                    cnt_next = '0;
                end else if (cnt == CNT_MAX) begin
                    out_next = s;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                cnt_next = cnt;
                out_next = out;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (en) begin
            cnt  <= cnt_next;
            out  <= out_next;
            rise <= out_next & ~out;
            fall <= ~out_next & out;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/glitch_filter_mc.sv
// Multi-channel glitch filter: CH independent channels sharing clock, reset, enable and mode.
// Latency SYNC_STAGES edges (+DEPTH-1 for FILTER/DEBOUNCE); no backpressure, en=0 holds state.
module glitch_filter_mc
    import glitch_filter_pkg::*;
#(
    parameter int CH          = 4,
    parameter int DEPTH       = 3,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] data,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy
);

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("glitch_filter_mc: MODE %0d is illegal", MODE);
    end
    if (CH < 1) begin : g_bad_ch
        $error("glitch_filter_mc: CH %0d must be >= 1", CH);
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("glitch_filter_mc: DEPTH %0d must be >= 1", DEPTH);
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("glitch_filter_mc: SYNC_STAGES %0d must be 0..4", SYNC_STAGES);
    end

    localparam mode_e MODE_E = mode_e'(MODE[1:0]);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        glitch_filter_ch #(
            .DEPTH       (DEPTH),
            .MODE        (MODE_E),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .data (data[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .busy (busy[i])
        );
    end

endmodule

// File: tb/tb_glitch_filter_mc.sv
// Bench for glitch_filter_mc: six instances (three modes at DEPTH=3/SYNC=2, three at DEPTH=1/SYNC=0)
// driven with shared stimulus and checked against a sample-history scoreboard plus directed timing points.
module tb_glitch_filter_mc;

    localparam int NI = 6;

    typedef logic [NI-1:0][15:0] exp_t;

    logic clk;
    logic rst;
    logic en;
    logic [3:0] data;

    logic [NI-1:0][3:0] d_out;
    logic [NI-1:0][3:0] d_rise;
    logic [NI-1:0][3:0] d_fall;
    logic [NI-1:0][3:0] d_busy;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t sbq[$];

    // Reference state: history of samples seen by the filter stage (newest at index 0).
    logic [3:0] m_hist [NI][3];
    logic [3:0] m_out  [NI];
    logic [3:0] d_m1;
    logic [3:0] d_m2;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        glitch_filter_mc #(
            .CH          (4),
            .DEPTH       ((gi < 3) ? 3 : 1),
            .MODE        (gi % 3),
            .SYNC_STAGES ((gi < 3) ? 2 : 0)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .data (data),
            .out  (d_out[gi]),
            .rise (d_rise[gi]),
            .fall (d_fall[gi]),
            .busy (d_busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int dep_of(input int i);
        return (i < 3) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] got_of(input int i);
        return {d_out[i], d_rise[i], d_fall[i], d_busy[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 3; j++) m_hist[i][j] = '0;
            m_out[i] = '0;
        end
        d_m1 = '0;
        d_m2 = '0;
    endtask

    // Predicts outputs after the coming edge from the currently driven data/en.
    task automatic model_edge();
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            logic [3:0] s, nxt, acc_or, acc_and, acc_dif, rs, fl, bz;
            int d;
            int md;
            d  = dep_of(i);
            md = i % 3;
            s  = (i < 3) ? d_m2 : data;
            rs = '0;
            fl = '0;
            if (en) begin
                m_hist[i][2] = m_hist[i][1];
                m_hist[i][1] = m_hist[i][0];
                m_hist[i][0] = s;
                acc_or  = '0;
                acc_and = '1;
                acc_dif = '1;
                for (int j = 0; j < d; j++) begin
                    acc_or  = acc_or  | m_hist[i][j];
                    acc_and = acc_and & m_hist[i][j];
                    acc_dif = acc_dif & (m_hist[i][j] ^ m_out[i]);
                end
                case (md)
                    0:       nxt = acc_or;
                    1:       nxt = acc_and;
                    default: nxt = m_out[i] ^ acc_dif;
                endcase
                rs = nxt & ~m_out[i];
                fl = ~nxt & m_out[i];
                m_out[i] = nxt;
            end
            bz = '0;
            if (d > 1) begin
                case (md)
                    0: for (int j = 0; j < d - 1; j++) bz = bz | m_hist[i][j];
                    1: bz = m_hist[i][0];
                    default: bz = m_hist[i][0] ^ m_out[i];
                endcase
            end
            e[i] = {m_out[i], rs, fl, bz};
        end
        d_m2 = d_m1;
        d_m1 = data;
        sbq.push_back(e);
    endtask

    // Called at a negedge: drive, predict, clock, compare, return at the next negedge.
    task automatic step(input logic [3:0] dv, input logic ev);
        exp_t e;
        data = dv;
        en   = ev;
        model_edge();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 16'd1, 16'd0);
        end else begin
            e = sbq.pop_front();
            for (int i = 0; i < NI; i++) chk($sformatf("sb_inst%0d", i), got_of(i), e[i]);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] dv;
        logic [3:0] prv;
        rst  = 1'b0;
        en   = 1'b1;
        data = '0;
        model_reset();
        #1 rst = 1'b1;
        #10;
        for (int i = 0; i < NI; i++) chk("reset_state", got_of(i), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Edges 1..29: concurrent pulses of 1, 2, 3 cycles and the 1,0,1,1,1 pattern.
        repeat (9) step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b0110, 1'b1);
        step(4'b1100, 1'b1);
        chk("str_out0_e12", d_out[0][0], 1'b1);
        chk("str_rise0_e12", d_rise[0][0], 1'b1);
        step(4'b1000, 1'b1);
        chk("flt_busy1_e13", d_busy[1][1], 1'b1);
        chk("flt_out1_e13", d_out[1][1], 1'b0);
        step(4'b1000, 1'b1);
        chk("str_out0_e14", d_out[0][0], 1'b1);
        chk("flt_rise2_e14", d_rise[1][2], 1'b1);
        chk("flt_out1_e14", d_out[1][1], 1'b0);
        step(4'b0000, 1'b1);
        chk("str_fall0_e15", d_fall[0][0], 1'b1);
        chk("str_out0_e15", d_out[0][0], 1'b0);
        chk("flt_out2_e15", d_out[1][2], 1'b0);
        chk("deb_out3_e15", d_out[2][3], 1'b0);
        step(4'b0000, 1'b1);
        chk("deb_rise3_e16", d_rise[2][3], 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("deb_out3_e18", d_out[2][3], 1'b1);
        step(4'b0000, 1'b1);
        chk("deb_fall3_e19", d_fall[2][3], 1'b1);
        repeat (10) step(4'b0000, 1'b1);

        // Edges 30..45: enable dropped for 5 cycles in the middle of a stretch window.
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("str_rise1_e32", d_rise[0][1], 1'b1);
        step(4'b0000, 1'b1);
        repeat (5) step(4'b0000, 1'b0);
        chk("en_hold_out1", d_out[0][1], 1'b1);
        chk("en_hold_busy1", d_busy[0][1], 1'b1);
        chk("en_hold_nofall", d_fall[0], 4'b0000);
        step(4'b0000, 1'b1);
        chk("en_resume_out1", d_out[0][1], 1'b1);
        step(4'b0000, 1'b1);
        chk("en_resume_fall1", d_fall[0][1], 1'b1);
        repeat (5) step(4'b0000, 1'b1);

        // Edges 46..52 then asynchronous reset between edges while a window is open.
        repeat (4) step(4'b0000, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("pre_rst_out1", d_out[0][1], 1'b1);
        chk("pre_rst_busy1", d_busy[0][1], 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk("rst_async", got_of(i), 16'h0000);
        data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000, 1'b1);
        chk("rst_no_fall1", d_fall[0][1], 1'b0);
        repeat (5) step(4'b0000, 1'b1);

        // Random data with enable held: DEPTH=1 instances are a one-cycle delay.
        prv = '0;
        for (int k = 0; k < 200; k++) begin
            dv = 4'($urandom);
            step(dv, 1'b1);
            for (int i = 3; i < NI; i++) begin
                chk("bnd_out",  d_out[i],  dv);
                chk("bnd_rise", d_rise[i], dv & ~prv);
                chk("bnd_fall", d_fall[i], ~dv & prv);
            end
            prv = dv;
        end

        // Random data and random enable across all instances.
        for (int k = 0; k < 200; k++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_filter_mc.md
# glitch_filter_mc

Multi-channel, parametrised glitch filter that turns asynchronous or noisy single-bit inputs into clean, registered levels with optional edge pulses. Each channel has a configurable synchroniser and one of three filtering modes: pulse stretch (OR over a window), minimum-width filter, or debounce. The block sits between external or cross-domain control lines and the synchronous control logic, which consumes `out`, `rise` and `fall`.

## Interface
- `CH`, 4: number of independent channels, ≥1.
- `DEPTH`, 3: window length in cycles, ≥1.
- `MODE`, 0: 0 = STRETCH, 1 = FILTER, 2 = DEBOUNCE; 3 is illegal and rejected at elaboration.
- `SYNC_STAGES`, 2: synchroniser flops per channel, 0..4; 0 means `data` is used directly.
- `clk`  in  1  single clock; everything samples on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable; when 0, the filter state and outputs hold.
- `data`  in  CH  raw channel inputs.
- `out`  out  CH  filtered levels, registered.
- `rise`  out  CH  one-cycle pulse when `out[i]` goes 0→1.
- `fall`  out  CH  one-cycle pulse when `out[i]` goes 1→0.
- `busy`  out  CH  channel counter is nonzero (a window is in progress).

## Operation
- `s[i]` is the synchroniser output; with SYNC_STAGES=0 it is `data[i]`. Synchronisers run regardless of `en`.
- Each channel has a counter `cnt`, width `max(1,$clog2(DEPTH))`, and registers `out`, `rise` and `fall`.
- STRETCH:
  - When `s=1`: `out<=1`, `cnt<=DEPTH-1`.
  - When `s=0` and `cnt≠0`: `cnt<=cnt-1`, `out` holds 1.
  - When `s=0` and `cnt=0`: `out<=0`.
  - Net effect: `out` equals the OR of the last DEPTH samples of `s`.
- FILTER:
  - When `s=0`: `out<=0`, `cnt<=0`.
  - When `s=1` and `cnt=DEPTH-1`: `out<=1`, `cnt` holds.
  - When `s=1` and `cnt<DEPTH-1`: `cnt<=cnt+1`.
  - Net effect: highs shorter than DEPTH samples are suppressed; falls pass immediately.
- DEBOUNCE:
  - When `s=out`: `cnt<=0`.
  - When `s≠out` and `cnt=DEPTH-1`: `out<=s`, `cnt<=0`.
  - When `s≠out` otherwise: `cnt<=cnt+1`.
  - Any sample that agrees with `out` restarts the count.
- DEPTH=1 in any mode: `out` is `s` delayed by one cycle.
- `rise<=out_next & ~out` and `fall<=~out_next & out` are updated on the same edge as `out`. When `en=0`, both are 0.
- `busy[i]` = `cnt≠0`, combinational from the register.
- `en=0`: `cnt` and `out` hold, and `rise`/`fall` are forced to 0. Resuming continues from the held state.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (asynchronous, immediate, including mid-window): all synchroniser flops, `cnt`, `out`, `rise`, `fall` and `busy` go to 0.
- Let edge k be the first edge that samples `data[i]=1`. Then `s` is high after edge k+SYNC_STAGES−1, and the earliest `out` change is at edge k+SYNC_STAGES.
  - With SYNC_STAGES=0, `out` changes at edge k.
- STRETCH: a high of L input cycles gives an `out` high of L+DEPTH−1 cycles.
- FILTER: an input high of L cycles gives an `out` high of max(0, L−DEPTH+1) cycles, starting DEPTH−1 cycles after the STRETCH start point.
- DEBOUNCE: `out` toggles DEPTH−1 cycles after the STRETCH start point, provided the new level is stable for DEPTH samples.
- The `rise`/`fall` pulses are coincident with the `out` transition and last exactly one cycle.

## Structure
- Package `glitch_filter_pkg` holds:
  - the mode enum `MODE_STRETCH`, `MODE_FILTER`, `MODE_DEBOUNCE`;
  - the counter-width function `cnt_w(DEPTH)`.
- Sub-module `glitch_filter_ch` implements one channel: synchroniser, counter, mode logic and edge registers.
- The top level instantiates `CH` copies via generate and holds the parameter-legality check.

## Test plan
All scenarios use CH=4, DEPTH=3, SYNC_STAGES=2 unless noted.
- **STRETCH:** 1-cycle pulse on `data[0]` sampled at edge 10 → `out[0]` high after edges 12..14 (3 cycles), `rise[0]` at 12, `fall[0]` at 15; other channels stay 0.
- **FILTER:** 2-cycle pulse → `out` stays 0 and `busy` pulses. 3-cycle pulse sampled at edge 10 → `out` high for exactly 1 cycle, rising at edge 14.
- **DEBOUNCE:** input 1,0,1,1,1 starting at edge 10 → the first 1 is rejected; `out` rises at edge 16 and stays high until 3 consecutive zeros.
- **Enable hold:** STRETCH, `en=0` for 5 cycles mid-window → `out` and `cnt` frozen, no `rise`/`fall`; on `en=1` the remaining window completes.
- **Reset mid-window:** `rst` asserted asynchronously between edges while `busy[1]=1` and `out[1]=1` → all outputs 0 immediately, no `fall` pulse after release.
- **Boundary:** DEPTH=1, SYNC_STAGES=0, all modes, random `data` on 4 channels → `out` equals `data` delayed by 1 cycle, and `rise`/`fall` match its edges.
